// File: rtl/deck_draw_arbiter.sv
// Round-robin card-draw arbiter for the shared deck: initial shuffle, top-pointer walk,
// valid/ready card delivery and refill/reshuffle on empty. Optional stats via DECK_ARB_STATS_EN.
module deck_draw_arbiter #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned DECK_SIZE   = 108,
  parameter int unsigned CARD_W      = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_PLAYERS-1:0]   i_req,
  input  logic [2*NUM_PLAYERS-1:0] i_req_cnt,
  output logic [NUM_PLAYERS-1:0]   o_grant,
  output logic                     o_card_valid,
  output logic [CARD_W-1:0]        o_card,
  input  logic                     i_card_ready,
  output logic                     o_done,
  output logic                     o_short,
  output logic [6:0]               o_deck_addr,
  input  logic [CARD_W-1:0]        i_deck_card,
  output logic                     o_shuffle_start,
  input  logic                     i_shuffle_done,
  output logic                     o_refill_req,
  input  logic                     i_refill_done,
  input  logic [6:0]               i_refill_count,
`ifdef DECK_ARB_STATS_EN
  output logic [15:0]              o_dealt_total,
  output logic [7:0]               o_refill_cnt,
`endif
  output logic [6:0]               o_remaining
);

  localparam int unsigned PW = (NUM_PLAYERS > 2) ? 2 : 1;
  localparam int unsigned RW = 7;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT_SHUF, S_IDLE, S_DEAL, S_REFILL, S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_PLAYERS-1:0] grant_q, grant_d;
  logic [2:0]             pending_q, pending_d;
  logic [RW-1:0]          remaining_q, remaining_d;
  logic [PW-1:0]          last_q, last_d;
  logic                   card_valid_q, card_valid_d;
  logic                   done_q, done_d;
  logic                   short_q, short_d;
  logic                   shuffle_q, shuffle_d;
  logic                   refill_q, refill_d;

  logic                   win_found;
  logic [PW-1:0]          win_idx;
  logic [PW-1:0]          cand;
  logic [1:0]             win_cnt;
  logic [2:0]             win_pending;
  logic [PW-1:0]          grant_idx;
  logic                   accept_c;

  assign accept_c = (state_q == S_DEAL) && card_valid_q && i_card_ready;

  // Round-robin search starting after the last grantee.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_PLAYERS; i++) begin
      cand = PW'((32'(last_q) + i) % NUM_PLAYERS);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's draw count and the index of the current grantee.
  always_comb begin
    win_cnt   = 2'b00;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (win_idx == PW'(i)) win_cnt = i_req_cnt[2*i +: 2];
      if (grant_q[i]) grant_idx = PW'(i);
    end
    case (win_cnt)
      2'b01:   win_pending = 3'd2;
      2'b10:   win_pending = 3'd4;
      default: win_pending = 3'd1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_INIT;
      grant_q      <= '0;
      pending_q    <= '0;
      remaining_q  <= RW'(DECK_SIZE);
      last_q       <= PW'(NUM_PLAYERS - 1);
      card_valid_q <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      shuffle_q    <= 1'b0;
      refill_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      pending_q    <= pending_d;
      remaining_q  <= remaining_d;
      last_q       <= last_d;
      card_valid_q <= card_valid_d;
      done_q       <= done_d;
      short_q      <= short_d;
      shuffle_q    <= shuffle_d;
      refill_q     <= refill_d;
    end
  end

  // Next-state logic; pulse outputs are set on the transition so they land one cycle later.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    pending_d    = pending_q;
    remaining_d  = remaining_q;
    last_d       = last_q;
    card_valid_d = card_valid_q;
    done_d       = 1'b0;
    short_d      = 1'b0;
    shuffle_d    = 1'b0;
    refill_d     = 1'b0;
    case (state_q)
      S_INIT: begin
        shuffle_d   = 1'b1;
        remaining_d = RW'(DECK_SIZE);
        state_d     = S_WAIT_SHUF;
      end
      S_WAIT_SHUF: begin
        if (i_shuffle_done) begin
          if (|grant_q) begin
            card_valid_d = (remaining_q != '0);
            state_d      = S_DEAL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (win_found) begin
          grant_d      = NUM_PLAYERS'(1) << win_idx;
          pending_d    = win_pending;
          card_valid_d = (remaining_q != '0);
          state_d      = S_DEAL;
        end
      end
      S_DEAL: begin
        if (accept_c) begin
          remaining_d = remaining_q - RW'(1);
          pending_d   = pending_q - 3'd1;
          if (pending_q == 3'd1) begin
            card_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_FINISH;
          end else if (remaining_q == RW'(1)) begin
            card_valid_d = 1'b0;
            refill_d     = 1'b1;
            state_d      = S_REFILL;
          end
        end else if (remaining_q == '0) begin
          // Granted on an already-empty deck.
          card_valid_d = 1'b0;
          refill_d     = 1'b1;
          state_d      = S_REFILL;
        end else begin
          card_valid_d = 1'b1;
        end
      end
      S_REFILL: begin
        if (i_refill_done) begin
          if (i_refill_count != '0) begin
            remaining_d = i_refill_count;
            shuffle_d   = 1'b1;
            state_d     = S_WAIT_SHUF;
          end else begin
            done_d  = 1'b1;
            short_d = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        grant_d = '0;
        last_d  = grant_idx;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign o_grant         = grant_q;
  assign o_card_valid    = card_valid_q;
  assign o_card          = i_deck_card;
  assign o_done          = done_q;
  assign o_short         = short_q;
  assign o_deck_addr     = remaining_q - RW'(1);
  assign o_shuffle_start = shuffle_q;
  assign o_refill_req    = refill_q;
  assign o_remaining     = remaining_q;

`ifdef DECK_ARB_STATS_EN
  logic [15:0] dealt_q;
  logic [7:0]  refill_cnt_q;

  // Saturating dealt-card count and wrapping refill-request count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dealt_q      <= '0;
      refill_cnt_q <= '0;
    end else begin
      if (accept_c && (dealt_q != 16'hFFFF)) dealt_q <= dealt_q + 16'd1;
      if (refill_q) refill_cnt_q <= refill_cnt_q + 8'd1;
    end
  end

  assign o_dealt_total = dealt_q;
  assign o_refill_cnt  = refill_cnt_q;
`endif

endmodule

// File: tb/tb_deck_draw_arbiter.sv
// Directed bench for deck_draw_arbiter: table of draw transactions plus hand-written
// sequences for round-robin, ready back-pressure, refill and reset mid-draw.
module tb_deck_draw_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DS = 108;
  localparam int unsigned CW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req;
  logic [2*NP-1:0] req_cnt;
  logic [NP-1:0]   grant;
  logic            card_valid;
  logic [CW-1:0]   card;
  logic            card_ready;
  logic            done;
  logic            short_o;
  logic [6:0]      deck_addr;
  logic [CW-1:0]   deck_card;
  logic            shuffle_start;
  logic            shuffle_done;
  logic            refill_req;
  logic            refill_done;
  logic [6:0]      refill_count;
  logic [6:0]      remaining;
`ifdef DECK_ARB_STATS_EN
  logic [15:0]     dealt_total;
  logic [7:0]      refill_cnt;
`endif

  always #5 clk = ~clk;

  deck_draw_arbiter #(.NUM_PLAYERS(NP), .DECK_SIZE(DS), .CARD_W(CW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_req_cnt      (req_cnt),
    .o_grant        (grant),
    .o_card_valid   (card_valid),
    .o_card         (card),
    .i_card_ready   (card_ready),
    .o_done         (done),
    .o_short        (short_o),
    .o_deck_addr    (deck_addr),
    .i_deck_card    (deck_card),
    .o_shuffle_start(shuffle_start),
    .i_shuffle_done (shuffle_done),
    .o_refill_req   (refill_req),
    .i_refill_done  (refill_done),
    .i_refill_count (refill_count),
`ifdef DECK_ARB_STATS_EN
    .o_dealt_total  (dealt_total),
    .o_refill_cnt   (refill_cnt),
`endif
    .o_remaining    (remaining)
  );

  function automatic logic [5:0] card_of(input logic [6:0] a);
    return a[5:0] ^ 6'h15;
  endfunction

  assign deck_card = card_of(deck_addr);

  typedef struct {
    int         player;
    logic [1:0] cnt;
    int         refill;
    int         exp_n;
    int         exp_short;
    int         exp_rem;
  } vec_t;

  vec_t vecs[10];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   model_rem = DS;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One draw with ready held high, answering refill/shuffle handshakes.
  task automatic run_draw(input int p, input logic [1:0] cnt, input int refill,
                          input int exp_n, input int exp_short, input int exp_rem,
                          input string tag);
    int accepts = 0;
    int seen    = 0;
    int sh      = 0;
    req[p]           = 1'b1;
    req_cnt[2*p +: 2] = cnt;
    card_ready       = 1'b1;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      tick();
      refill_done  = 1'b0;
      shuffle_done = 1'b0;
      if (refill_req) begin
        refill_done  = 1'b1;
        refill_count = 7'(refill);
        if (refill > 0) model_rem = refill;
      end
      if (shuffle_start) shuffle_done = 1'b1;
      if (card_valid) begin
        check($sformatf("%s_grant", tag), int'(grant), 1 << p);
        check($sformatf("%s_addr", tag), int'(deck_addr), model_rem - 1);
        check($sformatf("%s_card", tag), int'(card), int'(card_of(7'(model_rem - 1))));
        accepts++;
        model_rem--;
      end
      if (done) begin
        seen = 1;
        sh   = int'(short_o);
      end
    end
    req[p] = 1'b0;
    check($sformatf("%s_done_seen", tag), seen, 1);
    check($sformatf("%s_cards", tag), accepts, exp_n);
    check($sformatf("%s_short", tag), sh, exp_short);
    check($sformatf("%s_remaining", tag), int'(remaining), exp_rem);
  endtask

  initial begin
    int   lat;
    int   got;
    logic [CW-1:0] held;

    vecs[0] = '{2, 2'b10, 0,  4, 0, 104};
    vecs[1] = '{3, 2'b00, 0,  1, 0, 103};
    vecs[2] = '{0, 2'b01, 20, 2, 0, 19};
    vecs[3] = '{1, 2'b10, 0,  4, 0, 15};
    vecs[4] = '{2, 2'b10, 0,  4, 0, 11};
    vecs[5] = '{3, 2'b10, 0,  4, 0, 7};
    vecs[6] = '{0, 2'b10, 0,  4, 0, 3};
    vecs[7] = '{1, 2'b01, 0,  2, 0, 1};
    vecs[8] = '{2, 2'b11, 0,  1, 0, 0};
    vecs[9] = '{3, 2'b00, 0,  0, 1, 0};

    rst_n = 1'b0; req = '0; req_cnt = '0; card_ready = 1'b0;
    shuffle_done = 1'b0; refill_done = 1'b0; refill_count = '0;
    repeat (3) tick();
    check("rst_grant", int'(grant), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_shuffle", int'(shuffle_start), 0);
    check("rst_refill", int'(refill_req), 0);
    check("rst_remaining", int'(remaining), DS);

    rst_n = 1'b1;
    tick();
    check("init_shuffle_pulse", int'(shuffle_start), 1);
    req[0] = 1'b1;
    tick();
    check("shuffle_pulse_end", int'(shuffle_start), 0);
    tick();
    check("wait_shuf_ignores_req", int'(grant), 0);
    req[0] = 1'b0;
    shuffle_done = 1'b1;
    tick();
    shuffle_done = 1'b0;
    check("idle_grant", int'(grant), 0);
    check("idle_remaining", int'(remaining), DS);

    for (int i = 0; i < 2; i++)
      run_draw(vecs[i].player, vecs[i].cnt, vecs[i].refill, vecs[i].exp_n,
               vecs[i].exp_short, vecs[i].exp_rem, $sformatf("v%0d", i));

    // All players request at once: two full round-robin rounds.
    req = '1; req_cnt = '0; card_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      lat = 0; got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        tick();
        lat++;
        if (grant != '0) got = 1;
      end
      check($sformatf("rr%0d_grant", k), int'(grant), 1 << (k % 4));
      if (k > 0) check($sformatf("rr%0d_latency", k), lat, 2);
      check($sformatf("rr%0d_addr", k), int'(deck_addr), model_rem - 1);
      model_rem--;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        tick();
        if (done) got = 1;
      end
      check($sformatf("rr%0d_done", k), got, 1);
    end
    req = '0;
    check("rr_remaining", int'(remaining), 95);

    // Back-pressure: ready 1,0,0,1 on a two-card draw.
    card_ready = 1'b0;
    req[1] = 1'b1;
    req_cnt[3:2] = 2'b01;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      tick();
      if (card_valid) got = 1;
    end
    check("bp_valid", got, 1);
    check("bp_grant", int'(grant), 2);
    check("bp_addr0", int'(deck_addr), 94);
    card_ready = 1'b1;
    tick();
    card_ready = 1'b0;
    held = card;
    check("bp_rem_after1", int'(remaining), 94);
    check("bp_card1", int'(card), int'(card_of(7'd93)));
    tick();
    check("bp_stall1_valid", int'(card_valid), 1);
    check("bp_stall1_card", int'(card), int'(held));
    check("bp_stall1_rem", int'(remaining), 94);
    tick();
    check("bp_stall2_card", int'(card), int'(held));
    check("bp_stall2_done", int'(done), 0);
    card_ready = 1'b1;
    tick();
    check("bp_done", int'(done), 1);
    check("bp_short", int'(short_o), 0);
    check("bp_remaining", int'(remaining), 93);
    req[1] = 1'b0;
    model_rem = 93;

    for (int k = 0; k < 23; k++)
      run_draw(2, 2'b10, 0, 4, 0, 93 - 4 * (k + 1), $sformatf("drain%0d", k));

    for (int i = 2; i < 10; i++)
      run_draw(vecs[i].player, vecs[i].cnt, vecs[i].refill, vecs[i].exp_n,
               vecs[i].exp_short, vecs[i].exp_rem, $sformatf("v%0d", i));

    // Reset in the middle of a draw.
    req[0] = 1'b1;
    req_cnt[1:0] = 2'b10;
    card_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      tick();
      refill_done  = 1'b0;
      shuffle_done = 1'b0;
      if (refill_req) begin
        refill_done  = 1'b1;
        refill_count = 7'd50;
      end
      if (shuffle_start) shuffle_done = 1'b1;
      if (card_valid) got = 1;
    end
    refill_done  = 1'b0;
    shuffle_done = 1'b0;
    check("mid_valid", got, 1);
    check("mid_addr", int'(deck_addr), 49);
    card_ready = 1'b1;
    tick();
    card_ready = 1'b0;
    check("mid_remaining", int'(remaining), 49);
    rst_n = 1'b0;
    tick();
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_valid", int'(card_valid), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_remaining", int'(remaining), DS);
    req = '0;
    rst_n = 1'b1;
    tick();
    check("mid_rst_shuffle", int'(shuffle_start), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/deck_draw_arbiter.md
# deck_draw_arbiter

Arbitrates card draws from the shared 108-card deck between up to four player requesters. It issues the deck's initial shuffle, walks the deck top pointer, and delivers cards one at a time over a valid/ready handshake. When the deck empties mid-draw, it requests refill from the discard pile and reshuffles. It sits between the player hand controllers and the deck storage/shuffle block.

## Interface

- NUM_PLAYERS, 4: number of requesters, 2..4
- DECK_SIZE, 108: full deck card count, at most 127
- CARD_W, 6: card width, {color[1:0], value[3:0]}
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req  in  NUM_PLAYERS  draw request per player; held high until that player's o_done
- i_req_cnt  in  2*NUM_PLAYERS  per-player draw count: 00=1, 01=2, 10=4, 11=1
- o_grant  out  NUM_PLAYERS  one-hot owner of the current draw
- o_card_valid  out  1  o_card is valid for the granted player
- o_card  out  CARD_W  card at the deck top (i_deck_card passed through)
- i_card_ready  in  1  granted player accepts o_card
- o_done  out  1  one-cycle pulse when the granted draw completes
- o_short  out  1  one-cycle pulse with o_done when the draw ended with fewer cards than requested
- o_deck_addr  out  7  deck read index = remaining-1
- i_deck_card  in  CARD_W  deck word at o_deck_addr, combinational
- o_shuffle_start  out  1  one-cycle pulse that starts a deck shuffle
- i_shuffle_done  in  1  one-cycle pulse when the shuffle finishes
- o_refill_req  out  1  one-cycle pulse that requests discard-to-deck refill
- i_refill_done  in  1  one-cycle pulse when the refill finishes
- i_refill_count  in  7  cards placed in the deck; valid with i_refill_done
- o_remaining  out  7  cards left in the deck

## Operation

- States: INIT, WAIT_SHUF, IDLE, DEAL, REFILL, FINISH.
- INIT: pulse o_shuffle_start, then go to WAIT_SHUF. remaining = DECK_SIZE.
- WAIT_SHUF: wait for i_shuffle_done, then go to IDLE. Requests are ignored in this state.
- IDLE:
  - Round-robin arbitration. Search starts at the player after the last grantee; player 0 wins after reset.
  - The winner's count is latched into pending (3 bits). o_grant is set and the state goes to DEAL.
- DEAL:
  - o_card_valid = 1 while remaining > 0.
  - On valid & i_card_ready: remaining and pending both decrement.
  - When pending reaches 0, go to FINISH.
  - When remaining == 0 with pending > 0, drop o_card_valid, pulse o_refill_req and go to REFILL.
- REFILL:
  - On i_refill_done with i_refill_count > 0: remaining = i_refill_count, pulse o_shuffle_start and go to WAIT_SHUF. After the shuffle, return to DEAL with the grant and pending kept.
  - On i_refill_done with i_refill_count == 0: go to FINISH with the short flag set.
- FINISH:
  - Pulse o_done, and o_short if the short flag is set.
  - Clear o_grant and update the last grantee, then go to IDLE.
- o_card and o_card_valid hold stable while not accepted.
- i_req_cnt changes after latch are ignored. A grantee dropping i_req mid-draw is illegal and not checked.
- Arithmetic: remaining is 7 bits unsigned and never underflows, because a decrement is only possible when remaining > 0.

## Timing

- Reset values:
  - state INIT; o_grant 0; o_card_valid 0; o_done 0; o_short 0.
  - o_shuffle_start 0; o_refill_req 0; o_remaining DECK_SIZE.
  - Last grantee NUM_PLAYERS-1.
- o_shuffle_start is high in the first cycle after reset is released.
- Grant latency: request seen in IDLE at cycle t -> o_grant and o_card_valid high at t+1.
- Throughput: one card per cycle while i_card_ready is held high.
- Last accept at t -> o_done at t+1 -> IDLE at t+2 -> next grant at t+3.
- Empty deck: the accept that makes remaining 0 at t -> o_refill_req at t+1.
- i_refill_done at t -> o_shuffle_start at t+1.
- i_shuffle_done at t -> o_card_valid at t+1.
- Reset mid-draw: abort the draw without o_done and restart from INIT.
- A simultaneous i_req from all players resolves by round-robin only.

## Configuration

- DECK_ARB_STATS_EN defined:
  - Adds output o_dealt_total (16 bits), a saturating count of accepted cards, reset 0, held at 16'hFFFF once reached.
  - Adds output o_refill_cnt (8 bits), a wrapping count of o_refill_req pulses.
- Not defined: neither port nor its counters exist.

## Test plan

- Reset release -> o_shuffle_start pulse in cycle 1. After i_shuffle_done, o_remaining = 108 and state IDLE.
- Player 2 requests cnt=10 with ready always high -> 4 cards at o_deck_addr 107, 106, 105, 104. o_done one cycle after the 4th accept; o_remaining = 104.
- All four players request cnt=00 simultaneously -> grants go to players 0, 1, 2, 3 in order. A second round starts again at player 0.
- Ready toggles 1,0,0,1 during a cnt=01 draw -> o_card stays stable while not accepted, and exactly 2 accepts occur.
- remaining = 1, cnt=01, refill count 20 -> 1 card, o_refill_req, shuffle, then 1 more card. o_remaining = 19 and o_short = 0.
- remaining = 0, refill count 0 -> o_done and o_short pulse together with 0 cards delivered. Reset asserted mid-draw -> o_grant = 0 on the next edge.
